// File: rtl/fractal_sync_pkg.sv
// Shared types and helpers for the fractal synchronization CAM blocks.
package fractal_sync_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    CHECK  = 2'd2,
    RESP   = 2'd3
  } ctrl_state_e;

  // Index width for an N-entry structure; never narrower than one bit.
  function automatic int lidx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fractal_sync_prio_enc.sv
// Lowest-index-first priority encoder used for CAM hit and free-line selection.
module fractal_sync_prio_enc
  import fractal_sync_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]              i_vec,
  output logic [lidx_width(N)-1:0]  o_idx,
  output logic                      o_valid
);

  localparam int IW = lidx_width(N);

  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i_vec[i] && !o_valid) begin
        o_idx   = IW'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fractal_sync_cam_ctrl.sv
// Barrier-arrival sequencer for the fractal synchronization CAM: lookup,
// accumulate or allocate, completion detection, line clear and response.
module fractal_sync_cam_ctrl
  import fractal_sync_pkg::*;
#(
  parameter int SIG_WIDTH  = 8,
  parameter int DATA_WIDTH = 4,
  parameter int NUM_LINES  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [SIG_WIDTH-1:0]  req_sig_i,
  input  logic [DATA_WIDTH-1:0] req_src_i,
  input  logic [DATA_WIDTH-1:0] req_exp_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [SIG_WIDTH-1:0]  rsp_sig_o,
  output logic                  rsp_err_o,
  output logic [NUM_LINES-1:0]  cam_we_o,
  output logic [NUM_LINES-1:0]  cam_clear_o,
  output logic                  cam_cacc_o,
  output logic [SIG_WIDTH-1:0]  cam_sig_o,
  output logic [DATA_WIDTH-1:0] cam_data_o,
  input  logic [NUM_LINES-1:0]  cam_free_i,
  input  logic [NUM_LINES-1:0]  cam_hit_i,
  input  logic [DATA_WIDTH-1:0] cam_data_i
);

  localparam int LIDX_W = lidx_width(NUM_LINES);

  ctrl_state_e           r_state;
  ctrl_state_e           w_state_nxt;
  logic [SIG_WIDTH-1:0]  r_sig;
  logic [DATA_WIDTH-1:0] r_src;
  logic [DATA_WIDTH-1:0] r_exp;
  logic [LIDX_W-1:0]     r_idx;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [SIG_WIDTH-1:0]  r_rsp_sig;

  logic [LIDX_W-1:0]     w_hit_idx;
  logic                  w_hit_any;
  logic [LIDX_W-1:0]     w_free_idx;
  logic                  w_free_any;
  logic                  w_accept;
  logic                  w_illegal;
  logic                  w_complete;
  logic                  w_idx_load;
  logic [LIDX_W-1:0]     w_idx_nxt;
  logic                  w_rsp_load;
  logic                  w_rsp_err;
  logic [SIG_WIDTH-1:0]  w_rsp_sig;

  fractal_sync_prio_enc #(.N(NUM_LINES)) u_hit_enc (
    .i_vec   (cam_hit_i),
    .o_idx   (w_hit_idx),
    .o_valid (w_hit_any)
  );

  fractal_sync_prio_enc #(.N(NUM_LINES)) u_free_enc (
    .i_vec   (cam_free_i),
    .o_idx   (w_free_idx),
    .o_valid (w_free_any)
  );

  assign w_accept   = req_valid_i && (r_state == IDLE);
  assign w_illegal  = (req_exp_i == '0) || ((req_src_i & ~req_exp_i) != '0);
  // cam_data_i already reflects the OR performed at the end of LOOKUP.
  assign w_complete = ((cam_data_i & r_exp) == r_exp);

  always_comb begin
    w_state_nxt = r_state;
    req_ready_o = 1'b0;
    cam_we_o    = '0;
    cam_clear_o = '0;
    cam_cacc_o  = 1'b0;
    cam_sig_o   = '0;
    cam_data_o  = '0;
    w_idx_load  = 1'b0;
    w_idx_nxt   = r_idx;
    w_rsp_load  = 1'b0;
    w_rsp_err   = 1'b0;
    w_rsp_sig   = r_sig;
    case (r_state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (w_illegal) begin
            w_state_nxt = RESP;
            w_rsp_load  = 1'b1;
            w_rsp_err   = 1'b1;
            w_rsp_sig   = req_sig_i;
          end else begin
            w_state_nxt = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        cam_sig_o  = r_sig;
        cam_data_o = r_src;
        cam_cacc_o = 1'b1;
        if (w_hit_any) begin
          w_idx_load  = 1'b1;
          w_idx_nxt   = w_hit_idx;
          w_state_nxt = CHECK;
        end else if (w_free_any) begin
          w_idx_load  = 1'b1;
          w_idx_nxt   = w_free_idx;
          cam_we_o    = NUM_LINES'(1) << w_free_idx;
          w_state_nxt = CHECK;
        end else begin
          w_state_nxt = RESP;
          w_rsp_load  = 1'b1;
          w_rsp_err   = 1'b1;
        end
      end
      CHECK: begin
        cam_sig_o = r_sig;
        if (w_complete) begin
          cam_clear_o = NUM_LINES'(1) << r_idx;
          w_state_nxt = RESP;
          w_rsp_load  = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RESP: begin
        if (rsp_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_sig       <= '0;
      r_src       <= '0;
      r_exp       <= '0;
      r_idx       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_sig   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_sig <= req_sig_i;
        r_src <= req_src_i;
        r_exp <= req_exp_i;
      end
      if (w_idx_load) r_idx <= w_idx_nxt;
      if (w_rsp_load) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_rsp_err;
        r_rsp_sig   <= w_rsp_sig;
      end else if ((r_state == RESP) && rsp_ready_i) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_err_o   = r_rsp_err;
  assign rsp_sig_o   = r_rsp_sig;

endmodule

// File: tb/tb_fractal_sync_cam_ctrl.sv
// Directed bench for fractal_sync_cam_ctrl driving a small behavioural CAM.
module tb_fractal_sync_cam_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       req_valid_i, req_ready_o;
  logic [7:0] req_sig_i;
  logic [3:0] req_src_i, req_exp_i;
  logic       rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [7:0] rsp_sig_o;
  logic [3:0] cam_we_o, cam_clear_o;
  logic       cam_cacc_o;
  logic [7:0] cam_sig_o;
  logic [3:0] cam_data_o, cam_free_i, cam_hit_i, cam_data_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  fractal_sync_cam_ctrl #(.SIG_WIDTH(8), .DATA_WIDTH(4), .NUM_LINES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_sig_i(req_sig_i), .req_src_i(req_src_i), .req_exp_i(req_exp_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_sig_o(rsp_sig_o), .rsp_err_o(rsp_err_o),
    .cam_we_o(cam_we_o), .cam_clear_o(cam_clear_o), .cam_cacc_o(cam_cacc_o),
    .cam_sig_o(cam_sig_o), .cam_data_o(cam_data_o),
    .cam_free_i(cam_free_i), .cam_hit_i(cam_hit_i), .cam_data_i(cam_data_i)
  );

  // Behavioural CAM: write, OR-accumulate into the lowest hit line, clear.
  logic [3:0] m_valid;
  logic [7:0] m_sig [4];
  logic [3:0] m_dat [4];
  int         m_lo;

  always_comb begin
    cam_hit_i  = '0;
    cam_free_i = '0;
    for (int i = 0; i < 4; i++) begin
      cam_free_i[i] = !m_valid[i];
      cam_hit_i[i]  = m_valid[i] && (m_sig[i] == cam_sig_o);
    end
  end

  always_comb begin
    m_lo       = -1;
    cam_data_i = '0;
    for (int i = 3; i >= 0; i--) begin
      if (cam_hit_i[i]) begin
        m_lo       = i;
        cam_data_i = m_dat[i];
      end
    end
  end

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_valid <= '0;
      for (int i = 0; i < 4; i++) begin
        m_sig[i] <= '0;
        m_dat[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cam_clear_o[i]) begin
          m_valid[i] <= 1'b0;
          m_dat[i]   <= '0;
        end else if (cam_we_o[i]) begin
          m_valid[i] <= 1'b1;
          m_sig[i]   <= cam_sig_o;
          m_dat[i]   <= cam_data_o;
        end else if (cam_cacc_o && (m_lo == i)) begin
          m_dat[i] <= m_dat[i] | cam_data_o;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  // Called just after a falling edge; returns 1ns after the acceptance edge.
  task automatic issue(input logic [7:0] s, input logic [3:0] src, input logic [3:0] ex);
    n_tests++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL issue_ready got=%b exp=1", req_ready_o); end
    req_valid_i = 1'b1; req_sig_i = s; req_src_i = src; req_exp_i = ex;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0; req_sig_i = '0; req_src_i = '0; req_exp_i = '0;
  endtask

  task automatic handshake();
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i); rst_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_valid_i = 1'b0; req_sig_i = '0; req_src_i = '0; req_exp_i = '0; rsp_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    n_tests++; if (rsp_valid_o !== 1'b0 || rsp_err_o !== 1'b0 || rsp_sig_o !== 8'h00) begin n_fail++; $display("FAIL rst_rsp got=%b/%b/%h exp=0/0/00", rsp_valid_o, rsp_err_o, rsp_sig_o); end
    n_tests++; if ({cam_we_o, cam_clear_o, cam_cacc_o} !== 9'b0) begin n_fail++; $display("FAIL rst_cam got=%b exp=0", {cam_we_o, cam_clear_o, cam_cacc_o}); end
    rst_i = 1'b0;
    @(negedge clk_i);
    issue(8'h7A, 4'b0001, 4'b0011);
    @(negedge clk_i);
    n_tests++; if (cam_cacc_o !== 1'b1) begin n_fail++; $display("FAIL rst_lookup_cacc got=%b exp=1", cam_cacc_o); end
    rst_i = 1'b1; #1;
    n_tests++; if ({cam_we_o, cam_clear_o, cam_cacc_o, cam_sig_o, cam_data_o} !== 21'b0) begin n_fail++; $display("FAIL rst_mid_cam got=%b exp=0", {cam_we_o, cam_clear_o, cam_cacc_o}); end
    @(negedge clk_i); rst_i = 1'b0;
    @(negedge clk_i);
    n_tests++; if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_release got=%b/%b exp=1/0", req_ready_o, rsp_valid_o); end
    n_tests++; if (cam_free_i !== 4'b1111) begin n_fail++; $display("FAIL rst_no_alloc got=%b exp=1111", cam_free_i); end
    repeat (3) begin
      @(negedge clk_i);
      n_tests++; if (rsp_valid_o !== 1'b0 || cam_we_o !== 4'b0) begin n_fail++; $display("FAIL rst_dropped got=%b/%b exp=0/0000", rsp_valid_o, cam_we_o); end
    end
  endtask

  task automatic test_alloc_complete();
    do_reset();
    issue(8'h12, 4'b0001, 4'b0011);
    @(negedge clk_i);
    n_tests++; if (cam_we_o !== 4'b0001 || cam_cacc_o !== 1'b1) begin n_fail++; $display("FAIL alloc_we got=%b/%b exp=0001/1", cam_we_o, cam_cacc_o); end
    n_tests++; if (cam_sig_o !== 8'h12 || cam_data_o !== 4'b0001 || req_ready_o !== 1'b0) begin n_fail++; $display("FAIL alloc_bus got=%h/%b/%b exp=12/0001/0", cam_sig_o, cam_data_o, req_ready_o); end
    @(negedge clk_i);
    n_tests++; if (cam_clear_o !== 4'b0 || cam_cacc_o !== 1'b0 || cam_sig_o !== 8'h12) begin n_fail++; $display("FAIL alloc_check got=%b/%b/%h exp=0000/0/12", cam_clear_o, cam_cacc_o, cam_sig_o); end
    @(negedge clk_i);
    n_tests++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin n_fail++; $display("FAIL alloc_noresp got=%b/%b exp=0/1", rsp_valid_o, req_ready_o); end
    issue(8'h12, 4'b0010, 4'b0011);
    @(negedge clk_i);
    n_tests++; if (cam_we_o !== 4'b0 || cam_cacc_o !== 1'b1) begin n_fail++; $display("FAIL acc_lookup got=%b/%b exp=0000/1", cam_we_o, cam_cacc_o); end
    @(negedge clk_i);
    n_tests++; if (cam_clear_o !== 4'b0001 || cam_we_o !== 4'b0) begin n_fail++; $display("FAIL acc_clear got=%b/%b exp=0001/0000", cam_clear_o, cam_we_o); end
    @(negedge clk_i);
    n_tests++; if (rsp_valid_o !== 1'b1 || rsp_sig_o !== 8'h12 || rsp_err_o !== 1'b0 || req_ready_o !== 1'b0) begin n_fail++; $display("FAIL acc_rsp got=%b/%h/%b/%b exp=1/12/0/0", rsp_valid_o, rsp_sig_o, rsp_err_o, req_ready_o); end
    handshake();
    @(negedge clk_i);
    n_tests++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || cam_free_i !== 4'b1111) begin n_fail++; $display("FAIL acc_done got=%b/%b/%b exp=0/1/1111", rsp_valid_o, req_ready_o, cam_free_i); end
  endtask

  task automatic test_overflow();
    logic [3:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      e = 4'b0001 << i;
      issue(8'(i + 1), 4'b0001, 4'b1111);
      @(negedge clk_i);
      n_tests++; if (cam_we_o !== e) begin n_fail++; $display("FAIL fill_we%0d got=%b exp=%b", i, cam_we_o, e); end
      repeat (2) @(negedge clk_i);
    end
    issue(8'h05, 4'b0001, 4'b1111);
    @(negedge clk_i);
    n_tests++; if (cam_we_o !== 4'b0 || cam_cacc_o !== 1'b1) begin n_fail++; $display("FAIL ovf_lookup got=%b/%b exp=0000/1", cam_we_o, cam_cacc_o); end
    @(negedge clk_i);
    n_tests++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_sig_o !== 8'h05) begin n_fail++; $display("FAIL ovf_rsp got=%b/%b/%h exp=1/1/05", rsp_valid_o, rsp_err_o, rsp_sig_o); end
    handshake();
    @(negedge clk_i);
    n_tests++; if (rsp_valid_o !== 1'b0 || cam_free_i !== 4'b0000) begin n_fail++; $display("FAIL ovf_after got=%b/%b exp=0/0000", rsp_valid_o, cam_free_i); end
  endtask

  task automatic test_single();
    do_reset();
    issue(8'h20, 4'b1000, 4'b1000);
    @(negedge clk_i);
    n_tests++; if (cam_we_o !== 4'b0001) begin n_fail++; $display("FAIL single_we got=%b exp=0001", cam_we_o); end
    @(negedge clk_i);
    n_tests++; if (cam_clear_o !== 4'b0001 || cam_we_o !== 4'b0) begin n_fail++; $display("FAIL single_clear got=%b/%b exp=0001/0000", cam_clear_o, cam_we_o); end
    @(negedge clk_i);
    n_tests++; if (rsp_valid_o !== 1'b1 || rsp_sig_o !== 8'h20 || rsp_err_o !== 1'b0) begin n_fail++; $display("FAIL single_rsp got=%b/%h/%b exp=1/20/0", rsp_valid_o, rsp_sig_o, rsp_err_o); end
    n_tests++; if (cam_free_i !== 4'b1111) begin n_fail++; $display("FAIL single_free got=%b exp=1111", cam_free_i); end
    handshake();
    @(negedge clk_i);
  endtask

  task automatic test_illegal();
    do_reset();
    issue(8'h33, 4'b0010, 4'b0001);
    @(negedge clk_i);
    n_tests++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_sig_o !== 8'h33) begin n_fail++; $display("FAIL ill_rsp got=%b/%b/%h exp=1/1/33", rsp_valid_o, rsp_err_o, rsp_sig_o); end
    n_tests++; if ({cam_we_o, cam_clear_o, cam_cacc_o} !== 9'b0) begin n_fail++; $display("FAIL ill_cam got=%b exp=0", {cam_we_o, cam_clear_o, cam_cacc_o}); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      n_tests++; if (rsp_valid_o !== 1'b1 || rsp_sig_o !== 8'h33 || req_ready_o !== 1'b0) begin n_fail++; $display("FAIL ill_hold%0d got=%b/%h/%b exp=1/33/0", k, rsp_valid_o, rsp_sig_o, req_ready_o); end
    end
    handshake();
    @(negedge clk_i);
    n_tests++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || cam_free_i !== 4'b1111) begin n_fail++; $display("FAIL ill_done got=%b/%b/%b exp=0/1/1111", rsp_valid_o, req_ready_o, cam_free_i); end
    issue(8'h44, 4'b0000, 4'b0000);
    @(negedge clk_i);
    n_tests++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_sig_o !== 8'h44 || cam_cacc_o !== 1'b0) begin n_fail++; $display("FAIL ill_zero got=%b/%b/%h/%b exp=1/1/44/0", rsp_valid_o, rsp_err_o, rsp_sig_o, cam_cacc_o); end
    handshake();
    @(negedge clk_i);
  endtask

  task automatic test_duplicate();
    do_reset();
    issue(8'h50, 4'b0001, 4'b0011);
    repeat (3) @(negedge clk_i);
    issue(8'h50, 4'b0001, 4'b0011);
    @(negedge clk_i);
    n_tests++; if (cam_we_o !== 4'b0 || cam_cacc_o !== 1'b1) begin n_fail++; $display("FAIL dup_lookup got=%b/%b exp=0000/1", cam_we_o, cam_cacc_o); end
    @(negedge clk_i);
    n_tests++; if (cam_clear_o !== 4'b0) begin n_fail++; $display("FAIL dup_noclear got=%b exp=0000", cam_clear_o); end
    @(negedge clk_i);
    n_tests++; if (rsp_valid_o !== 1'b0 || m_valid !== 4'b0001 || m_dat[0] !== 4'b0001) begin n_fail++; $display("FAIL dup_state got=%b/%b/%b exp=0/0001/0001", rsp_valid_o, m_valid, m_dat[0]); end
    issue(8'h50, 4'b0010, 4'b0011);
    repeat (3) @(negedge clk_i);
    n_tests++; if (rsp_valid_o !== 1'b1 || rsp_sig_o !== 8'h50 || rsp_err_o !== 1'b0) begin n_fail++; $display("FAIL dup_rsp got=%b/%h/%b exp=1/50/0", rsp_valid_o, rsp_sig_o, rsp_err_o); end
    handshake();
    @(negedge clk_i);
    n_tests++; if (cam_free_i !== 4'b1111) begin n_fail++; $display("FAIL dup_free got=%b exp=1111", cam_free_i); end
  endtask

  initial begin
    test_reset();
    test_alloc_complete();
    test_overflow();
    test_single();
    test_illegal();
    test_duplicate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fractal_sync_cam_ctrl.md
Name: fractal_sync_cam_ctrl

Overview:
Sequencer for the fractal synchronization CAM. It accepts barrier-arrival requests, each carrying a barrier signature, an arriving-participant mask and an expected-participant mask. For each request it looks up the CAM, either accumulates into an existing line or allocates a free line, and detects barrier completion. On completion it clears the line and emits one completion response. It sits between the synchronization tree node's request port and a single CAM instance, whose per-line hit vector is brought out to this block.

Parameters:
SIG_WIDTH, 8, barrier signature width
DATA_WIDTH, 4, participant mask width (one bit per participant)
NUM_LINES, 4, CAM lines; line index width LIDX_W = max(1, clog2(NUM_LINES))

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
req_valid_i  in  1  arrival request valid
req_ready_o  out  1  controller accepts a request
req_sig_i  in  SIG_WIDTH  barrier signature
req_src_i  in  DATA_WIDTH  arriving participant mask
req_exp_i  in  DATA_WIDTH  expected full participant mask
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed
rsp_sig_o  out  SIG_WIDTH  signature of completed or failed barrier
rsp_err_o  out  1  1 = no free line or illegal request
cam_we_o  out  NUM_LINES  per-line write enable (at most one-hot)
cam_clear_o  out  NUM_LINES  per-line clear (at most one-hot)
cam_cacc_o  out  1  accumulate enable
cam_sig_o  out  SIG_WIDTH  lookup/write signature
cam_data_o  out  DATA_WIDTH  write/accumulate data
cam_free_i  in  NUM_LINES  per-line free flags
cam_hit_i  in  NUM_LINES  per-line present flags
cam_data_i  in  DATA_WIDTH  data of the lowest-index hit line

Behaviour:
- States: IDLE, LOOKUP, CHECK, RESP. All registers reset asynchronously on rst_i=1: state=IDLE, latched sig/src/exp/idx=0, rsp_valid_o=0, rsp_err_o=0, rsp_sig_o=0.
- CAM-side outputs are combinational from the state. They are 0 outside the cycles listed below, including while rst_i is asserted.
- IDLE: req_ready_o=1. On req_valid_i&req_ready_o, latch sig, src and exp.
  - If req_exp_i==0, or req_src_i & ~req_exp_i is non-zero, go to RESP with err=1. The CAM is not touched.
  - Otherwise go to LOOKUP.
- req_ready_o=0 in every state other than IDLE.
- LOOKUP: cam_sig_o=sig, cam_data_o=src, cam_cacc_o=1.
  - Any cam_hit_i bit set: idx = lowest set hit bit; no write. The CAM ORs src into the line at the clock edge. Go to CHECK.
  - No hit and any free line: idx = lowest set cam_free_i bit; cam_we_o[idx]=1. Go to CHECK.
  - No hit and no free line: go to RESP with err=1.
- CHECK: cam_sig_o=sig, cam_cacc_o=0. Complete when (cam_data_i & exp) == exp.
  - Complete: cam_clear_o[idx]=1 for this one cycle; go to RESP with err=0.
  - Not complete: go to IDLE with no response.
- RESP: rsp_valid_o=1 and rsp_sig_o=sig, both held stable until rsp_ready_i is high. Then go to IDLE. rsp_valid_o is registered.
- Latency: request accepted at edge T; LOOKUP runs in cycle T+1, CHECK in T+2, rsp_valid_o rises at T+3.
  - Error detected in LOOKUP: rsp_valid_o at T+2.
  - Illegal request: rsp_valid_o at T+1.
- Throughput:
  - Non-completing arrival: 3 cycles per request.
  - Completing arrival: 3 cycles plus the response handshake.
- Duplicate arrival (src bits already set in the line): OR is idempotent. No error, no double count.
- Single-participant barrier (src==exp, no hit): line allocated in LOOKUP, completed and cleared in CHECK. The line is free again at T+3.
- cam_we_o and cam_clear_o are never asserted in the same cycle. A line is never written while it is cleared.
- Reset mid-operation: the in-flight request is dropped and no response is produced. The CAM is reset by the same reset domain.

Decomposition:
- Shared package fractal_sync_pkg gains:
  - ctrl_state_e enum (IDLE, LOOKUP, CHECK, RESP)
  - a helper function for LIDX_W
- One sub-module: fractal_sync_prio_enc (parameter N; in vec[N]; out idx[max(1,clog2 N)], out valid). It is instantiated twice, for hit selection and for free-line selection.

Test Plan:
- Reset: assert rst_i mid-LOOKUP -> all CAM outputs 0, req_ready_o=1, rsp_valid_o=0 the cycle after release.
- Allocate then complete: sig=0x12, exp=4'b0011; src=4'b0001 -> cam_we_o=4'b0001, no response. Then src=4'b0010 -> cam_cacc_o=1, cam_clear_o=4'b0001 in CHECK, rsp_valid_o=1, rsp_sig_o=0x12, rsp_err_o=0 at T+3.
- Overflow: fill 4 lines with sig=0x01..0x04 (exp=4'b1111, src=4'b0001). Then sig=0x05 -> no write, rsp_err_o=1, rsp_sig_o=0x05 at T+2.
- Single participant: sig=0x20, src=exp=4'b1000 on an empty CAM -> we then clear on line 0, response at T+3, cam_free_i=4'b1111 afterwards.
- Illegal request: exp=4'b0001, src=4'b0010 -> rsp_err_o=1 at T+1, no CAM activity. rsp_ready_i held 0 for 5 cycles -> rsp_valid_o and rsp_sig_o stable, req_ready_o=0.
- Duplicate arrival: src=4'b0001 twice on exp=4'b0011 -> no response, line data stays 4'b0001. Then src=4'b0010 -> completion response.
